irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Machine timer and external interrupt controller.
// Memory-mapped mtime/mtimecmp, enables, pending bits and prescaler.
module irq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  addr,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        ext_irq_in,
   input  logic        mie_global,
   input  logic        trap_ack,
   output logic        interrupt,
   output logic [31:0] irq_cause
);

   localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [1:0]  en_q, en_d;
   logic        pend_t_q, pend_t_d;
   logic        pend_e_q, pend_e_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        sync3_q, sync3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic [31:0] cause_q, cause_d;

   logic wr_mlo, wr_mhi, wr_presc, w1c, ext_rise, inc, ack_ext;

   // Write decode, prescaler tick and edge detection.
   always_comb begin
      wr_mlo   = wen && (addr == 3'd0);
      wr_mhi   = wen && (addr == 3'd1);
      wr_presc = wen && (addr == 3'd6);
      w1c      = wen && (addr == 3'd5) && wdata[1];
      ext_rise = sync2_q && !sync3_q;
      inc      = (pcnt_q == presc_q) && !(wr_mlo || wr_mhi);
      // trap_ack only counts as taking the external trap if one was raised.
      ack_ext  = trap_ack && irq_q && (cause_q == CAUSE_EXT);
   end

   // Next-state for timer, compare, enables and prescaler.
   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      presc_d    = presc_q;
      pcnt_d     = pcnt_q + 16'd1;
      if (wr_mlo || wr_mhi) begin
         if (wr_mlo) mtime_d[31:0]  = wdata;
         if (wr_mhi) mtime_d[63:32] = wdata;
      end else if (inc) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (wr_mlo || wr_mhi || wr_presc || inc) pcnt_d = 16'd0;
      if (wen && addr == 3'd2) mtimecmp_d[31:0]  = wdata;
      if (wen && addr == 3'd3) mtimecmp_d[63:32] = wdata;
      if (wen && addr == 3'd4) en_d = wdata[1:0];
      if (wr_presc) presc_d = wdata[15:0];
   end

   // Next-state for synchronizer, pending bits and outputs.
   always_comb begin
      sync1_d  = ext_irq_in;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      pend_t_d = (mtime_q >= mtimecmp_q);
      pend_e_d = pend_e_q;
      if (ext_rise)            pend_e_d = 1'b1;
      else if (w1c || ack_ext) pend_e_d = 1'b0;
      irq_d = mie_global && ((pend_e_q && en_q[1]) ||
                             (pend_t_q && en_q[0])) && !trap_ack;
      if (trap_ack)                   cause_d = cause_q;
      else if (pend_e_q && en_q[1])   cause_d = CAUSE_EXT;
      else if (pend_t_q && en_q[0])   cause_d = CAUSE_TMR;
      else                            cause_d = 32'd0;
   end

   // Registered read port; value is taken before any same-cycle write.
   always_comb begin
      rdata_d = rdata_q;
      if (ren) begin
         case (addr)
            3'd0:    rdata_d = mtime_q[31:0];
            3'd1:    rdata_d = mtime_q[63:32];
            3'd2:    rdata_d = mtimecmp_q[31:0];
            3'd3:    rdata_d = mtimecmp_q[63:32];
            3'd4:    rdata_d = {30'd0, en_q};
            3'd5:    rdata_d = {30'd0, pend_e_q, pend_t_q};
            3'd6:    rdata_d = {16'd0, presc_q};
            default: rdata_d = 32'd0;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= '1;
         en_q       <= 2'd0;
         pend_t_q   <= 1'b0;
         pend_e_q   <= 1'b0;
         presc_q    <= 16'd0;
         pcnt_q     <= 16'd0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         rdata_q    <= 32'd0;
         irq_q      <= 1'b0;
         cause_q    <= 32'd0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         pend_t_q   <= pend_t_d;
         pend_e_q   <= pend_e_d;
         presc_q    <= presc_d;
         pcnt_q     <= pcnt_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         cause_q    <= cause_d;
      end
   end

   assign rdata     = rdata_q;
   assign interrupt = irq_q;
   assign irq_cause = cause_q;

endmodule
